// File: rtl/serial_load_pkg.sv
// Shared definitions for the serial load controller: state codes,
// output bit positions and a counter width helper.
package serial_load_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_WAIT4DATA = 3'b001,
    ST_READ      = 3'b010,
    ST_SHIFT     = 3'b011,
    ST_SET_DONE  = 3'b100,
    ST_ERROR     = 3'b101
  } state_t;

  // Registered output vector layout
  localparam int OUT_W      = 5;
  localparam int O_RDENA    = 0;
  localparam int O_SHFT_ENA = 1;
  localparam int O_SET_DONE = 2;
  localparam int O_ERR      = 3;
  localparam int O_BUSY     = 4;

  // Bits needed to hold the values 0..n-1, never less than one bit
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tmr_vote.sv
// W-bit bitwise two-out-of-three majority voter.
module tmr_vote #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_load_ctrl.sv
// Unloads NUM_WORDS words from an upstream FIFO and serialises each into a
// downstream shift register: one RDENA pulse, then WORD_BITS SHFT_ENA cycles.
// All registers clock on the falling edge of CLK. With TMR=1 every register
// group is held in three copies, each copy computing its next value from the
// voted present value, so a single upset is scrubbed on the next edge.
module serial_load_ctrl
  import serial_load_pkg::*;
#(
  parameter  int WORD_BITS   = 16,
  parameter  int NUM_WORDS   = 19,
  parameter  int TIMEOUT_CYC = 0,
  parameter  int TMR         = 1,
  localparam int WCW         = cnt_w(NUM_WORDS + 1)
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           START,
  input  logic           ABORT,
  input  logic           MT,
  output logic           RDENA,
  output logic           SHFT_ENA,
  output logic           SET_DONE,
  output logic           ERR,
  output logic           BUSY,
  output logic [WCW-1:0] WORD_CNT
);

  localparam int BCW = cnt_w(WORD_BITS);
  localparam int TCW = cnt_w(TIMEOUT_CYC + 1);
  localparam int NC  = (TMR != 0) ? 3 : 1;

  localparam logic [BCW-1:0] BC_LAST = BCW'(WORD_BITS - 1);
  localparam logic [TCW-1:0] TC_LAST = TCW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam logic [WCW-1:0] WC_LAST = WCW'(NUM_WORDS);

  // Voted (or single-copy) present values seen by every copy's next logic
  logic [2:0]       st_v;
  logic [WCW-1:0]   wc_v;
  logic [BCW-1:0]   bc_v;
  logic [TCW-1:0]   tc_v;
  logic [OUT_W-1:0] out_v;

  // All copies concatenated, copy gi at slice gi
  logic [NC*3-1:0]     st_all;
  logic [NC*WCW-1:0]   wc_all;
  logic [NC*BCW-1:0]   bc_all;
  logic [NC*TCW-1:0]   tc_all;
  logic [NC*OUT_W-1:0] out_all;

  genvar gi;
  generate
    for (gi = 0; gi < NC; gi++) begin : g_copy
      (* keep = "true", preserve *) logic [2:0]       state_reg;
      (* keep = "true", preserve *) logic [WCW-1:0]   wc_reg;
      (* keep = "true", preserve *) logic [BCW-1:0]   bc_reg;
      (* keep = "true", preserve *) logic [TCW-1:0]   tc_reg;
      (* keep = "true", preserve *) logic [OUT_W-1:0] out_reg;

      state_t           st_next;
      logic [WCW-1:0]   wc_next;
      logic [BCW-1:0]   bc_next;
      logic [TCW-1:0]   tc_next;
      logic [OUT_W-1:0] out_next;

      // Next state, counters and outputs decoded from the next state
      always_comb begin
        st_next = ST_IDLE;
        wc_next = wc_v;
        bc_next = bc_v;
        tc_next = tc_v;
        if (ABORT && (st_v != ST_IDLE)) begin
          st_next = ST_IDLE;
          wc_next = '0;
          bc_next = '0;
          tc_next = '0;
        end else begin
          case (st_v)
            ST_IDLE: begin
              if (START) begin
                st_next = ST_WAIT4DATA;
                wc_next = '0;
                tc_next = '0;
              end else begin
                st_next = ST_IDLE;
              end
            end
            ST_WAIT4DATA: begin
              if (!MT) begin
                st_next = ST_READ;
                wc_next = wc_v + WCW'(1);
                bc_next = '0;
              end else if ((TIMEOUT_CYC != 0) && (tc_v == TC_LAST)) begin
                st_next = ST_ERROR;
              end else begin
                st_next = ST_WAIT4DATA;
                if (TIMEOUT_CYC != 0) tc_next = tc_v + TCW'(1);
              end
            end
            ST_READ: begin
              st_next = ST_SHIFT;
              bc_next = '0;
            end
            ST_SHIFT: begin
              if (bc_v == BC_LAST) begin
                bc_next = '0;
                if (wc_v == WC_LAST) begin
                  st_next = ST_SET_DONE;
                end else if (!MT) begin
                  // Next word is already available: read it with no gap
                  st_next = ST_READ;
                  wc_next = wc_v + WCW'(1);
                end else begin
                  st_next = ST_WAIT4DATA;
                  tc_next = '0;
                end
              end else begin
                st_next = ST_SHIFT;
                bc_next = bc_v + BCW'(1);
              end
            end
            ST_SET_DONE: st_next = START ? ST_SET_DONE : ST_IDLE;
            ST_ERROR:    st_next = START ? ST_ERROR : ST_IDLE;
            default: begin
              // Unused codes fall back to IDLE with clean counters
              st_next = ST_IDLE;
              wc_next = '0;
              bc_next = '0;
              tc_next = '0;
            end
          endcase
        end
        out_next             = '0;
        out_next[O_RDENA]    = (st_next == ST_READ);
        out_next[O_SHFT_ENA] = (st_next == ST_SHIFT);
        out_next[O_SET_DONE] = (st_next == ST_SET_DONE);
        out_next[O_ERR]      = (st_next == ST_ERROR);
        out_next[O_BUSY]     = (st_next == ST_WAIT4DATA) || (st_next == ST_READ) ||
                               (st_next == ST_SHIFT);
      end

      // Copy registers: falling-edge clocked, asynchronously cleared
      always_ff @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          state_reg <= ST_IDLE;
          wc_reg    <= '0;
          bc_reg    <= '0;
          tc_reg    <= '0;
          out_reg   <= '0;
        end else begin
          state_reg <= st_next;
          wc_reg    <= wc_next;
          bc_reg    <= bc_next;
          tc_reg    <= tc_next;
          out_reg   <= out_next;
        end
      end

      assign st_all[gi*3 +: 3]         = state_reg;
      assign wc_all[gi*WCW +: WCW]     = wc_reg;
      assign bc_all[gi*BCW +: BCW]     = bc_reg;
      assign tc_all[gi*TCW +: TCW]     = tc_reg;
      assign out_all[gi*OUT_W +: OUT_W] = out_reg;
    end

    if (TMR != 0) begin : g_vote
      tmr_vote #(.W(3)) u_vote_st (
        .a(st_all[0 +: 3]), .b(st_all[3 +: 3]), .c(st_all[6 +: 3]), .y(st_v));
      tmr_vote #(.W(WCW)) u_vote_wc (
        .a(wc_all[0 +: WCW]), .b(wc_all[WCW +: WCW]), .c(wc_all[2*WCW +: WCW]), .y(wc_v));
      tmr_vote #(.W(BCW)) u_vote_bc (
        .a(bc_all[0 +: BCW]), .b(bc_all[BCW +: BCW]), .c(bc_all[2*BCW +: BCW]), .y(bc_v));
      tmr_vote #(.W(TCW)) u_vote_tc (
        .a(tc_all[0 +: TCW]), .b(tc_all[TCW +: TCW]), .c(tc_all[2*TCW +: TCW]), .y(tc_v));
      tmr_vote #(.W(OUT_W)) u_vote_out (
        .a(out_all[0 +: OUT_W]), .b(out_all[OUT_W +: OUT_W]),
        .c(out_all[2*OUT_W +: OUT_W]), .y(out_v));
    end else begin : g_single
      assign st_v  = st_all;
      assign wc_v  = wc_all;
      assign bc_v  = bc_all;
      assign tc_v  = tc_all;
      assign out_v = out_all;
    end
  endgenerate

  assign RDENA    = out_v[O_RDENA];
  assign SHFT_ENA = out_v[O_SHFT_ENA];
  assign SET_DONE = out_v[O_SET_DONE];
  assign ERR      = out_v[O_ERR];
  assign BUSY     = out_v[O_BUSY];
  assign WORD_CNT = wc_v;

endmodule

// File: doc/serial_load_ctrl.md
Name: serial_load_ctrl

Overview:
Parametrised controller that unloads NUM_WORDS words from an upstream FIFO and serialises each one into a downstream shift register. For each word it pulses RDENA once and then asserts SHFT_ENA for WORD_BITS cycles. It is the generalised successor of the fixed 16-bit × 19-word loader. Additions over that loader:
- FIFO-empty check before every word, not only before the first.
- Underrun timeout with an error state.
- Abort input.
- Progress and busy outputs.
- Optional TMR hardening.

Parameters:
- WORD_BITS, 16: shift cycles per word; legal range 2..256.
- NUM_WORDS, 19: words per load sequence; legal range 1..1023.
- TIMEOUT_CYC, 0: maximum consecutive MT-high cycles tolerated in WAIT4DATA before an error; 0 disables the timeout.
- TMR, 1: 1 triplicates all state, counter and output registers behind majority voters; 0 uses single copies.

Ports:
- CLK  in  1  system clock; all registers update on the falling edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  level request; sampled in IDLE, must be released after DONE/ERR to re-arm.
- ABORT  in  1  synchronous abort; highest priority after reset.
- MT  in  1  upstream FIFO empty flag.
- RDENA  out  1  FIFO read strobe; one cycle per word.
- SHFT_ENA  out  1  downstream shift enable.
- SET_DONE  out  1  held high in SET_DONE state.
- ERR  out  1  held high in ERROR state.
- BUSY  out  1  high in WAIT4DATA, READ and SHIFT.
- WORD_CNT  out  $clog2(NUM_WORDS+1)  number of words read so far in the current sequence.

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE, all counters 0, all outputs 0. A reset asserted mid-sequence aborts the sequence immediately with no further strobes.
- All outputs are registered and decoded from next-state, so an output is valid in the same cycle the FSM enters the state.
- States and transitions, evaluated in priority order each falling edge:
  - Any non-IDLE state with ABORT=1 -> IDLE. Counters clear; no DONE and no ERR.
  - IDLE: START=1 -> WAIT4DATA and WORD_CNT <= 0; otherwise stay.
  - WAIT4DATA: MT=0 -> READ. MT=1 -> stay and increment the timeout counter; when TIMEOUT_CYC≠0 and the counter reaches TIMEOUT_CYC -> ERROR. The timeout counter clears on every entry to WAIT4DATA.
  - READ: RDENA=1, WORD_CNT increments, bit counter <= 0; always -> SHIFT next cycle.
  - SHIFT: SHFT_ENA=1 and the bit counter increments. On the cycle where bit counter = WORD_BITS-1 (the last shift):
    - WORD_CNT = NUM_WORDS -> SET_DONE;
    - else MT=0 -> READ (back-to-back, no gap);
    - else -> WAIT4DATA.
  - SET_DONE: SET_DONE=1; START=0 -> IDLE, else stay.
  - ERROR: ERR=1; START=0 -> IDLE, else stay.
- Timing: each word takes 1 + WORD_BITS cycles when MT stays low. With MT continuously low, SET_DONE rises 1 + NUM_WORDS·(WORD_BITS+1) cycles after START is first sampled.
- Simultaneous events:
  - ABORT beats every transition in the same cycle.
  - MT is ignored inside READ and SHIFT except on the last shift cycle.
  - START dropping during a sequence does not stop it; only ABORT does.
- Widths: the bit counter is $clog2(WORD_BITS) bits and the timeout counter is $clog2(TIMEOUT_CYC+1) bits. Neither counter wraps inside legal parameter ranges.
- State encoding is 3 bits. Undefined codes (110, 111) recover to IDLE on the next edge.
- TMR=1 rules:
  - Each copy computes its next value from the voted state and counters.
  - Outputs are the vote of the three output registers.
  - A single upset in any copy corrects within one cycle and causes no output glitch.
  - Registers carry keep/preserve attributes.

Decomposition:
- Shared package serial_load_pkg:
  - state encoding constants IDLE=000, WAIT4DATA=001, READ=010, SHIFT=011, SET_DONE=100, ERROR=101;
  - a width-helper function for the counters.
- One natural sub-module: tmr_vote #(W), a W-bit majority voter. Instantiate it per triplicated register group when TMR=1; bypass it when TMR=0.

Test Plan:
- Defaults, MT=0 throughout, START pulsed high and held: expect 19 RDENA pulses and 304 SHFT_ENA cycles in 16-cycle runs with no gaps. SET_DONE rises 324 cycles after START is sampled; WORD_CNT=19. Drop START -> IDLE next edge.
- Defaults, MT raised for 5 cycles at the end of word 7: FSM enters WAIT4DATA with BUSY=1 and SHFT_ENA=0. It resumes READ on the first MT=0 edge; totals are still 19/304.
- TIMEOUT_CYC=10, MT held high after START: ERR rises on the 10th MT-high cycle in WAIT4DATA with no RDENA. ERR holds until START=0, then IDLE.
- ABORT asserted in word 3 during SHIFT: SHFT_ENA drops and FSM returns to IDLE next edge; WORD_CNT=0, no SET_DONE. A new START runs the full 19 words.
- WORD_BITS=4, NUM_WORDS=1: sequence is RDENA ×1, SHFT_ENA ×4, SET_DONE at cycle 6. RST_N pulsed low mid-shift -> all outputs 0 immediately (asynchronously).
- TMR=1, force one copy of the state register to 111 mid-SHIFT: outputs stay unchanged and the copy re-converges on the next edge.
